// File: rtl/winocnn_pkg.sv
// winocnn_pkg: shared types and constants for the Winograd weight path
package winocnn_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, READY, ACTIVE} wt_state_t;
  localparam int WT_TILE = 16;
  localparam int WT_MAX_OUT = 4;
endpackage

// File: rtl/wt_addr_gen.sv
// wt_addr_gen: weight word address of coeff k of filter (od, id)
module wt_addr_gen #(
  parameter int ADDR_W = 16,
  parameter int KW = 4
) (
  input  logic [ADDR_W-1:0] base,
  input  logic [7:0]        od,
  input  logic [3:0]        id,
  input  logic [3:0]        total_id,
  input  logic [KW-1:0]     k,
  output logic [ADDR_W-1:0] addr
);
  logic [ADDR_W-1:0] tile_idx;
  always_comb begin
    tile_idx = ADDR_W'(od) * ADDR_W'(total_id) + ADDR_W'(id);
    addr = base + (tile_idx << KW) + ADDR_W'(k);
  end
endmodule

// File: rtl/weight_fetch_controller.sv
// weight_fetch_controller: loads two Winograd filter tiles from weight memory and holds them for the PE array
// Optional WT_REUSE_EN: a prepare for the already-loaded indices skips the fetch.
module weight_fetch_controller
  import winocnn_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int TILE = WT_TILE,
  parameter int ADDR_W = 16,
  parameter int MAX_OUT = WT_MAX_OUT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               weight_od1_i,
  input  logic [7:0]               weight_od2_i,
  input  logic [3:0]               weight_id_i,
  input  logic                     weight_prepare_i,
  input  logic                     weight_start_i,
  input  logic [3:0]               total_id_i,
  input  logic [7:0]               total_od_i,
  input  logic [ADDR_W-1:0]        wt_base_i,
  output logic                     weight_ready_o,
  output logic                     mem_req_o,
  output logic [ADDR_W-1:0]        mem_addr_o,
  input  logic                     mem_gnt_i,
  input  logic                     mem_rvalid_i,
  input  logic [DATA_W-1:0]        mem_rdata_i,
  output logic                     wt_valid_o,
  output logic [TILE*DATA_W-1:0]   wt_f1_o,
  output logic [TILE*DATA_W-1:0]   wt_f2_o
);
  localparam int KW = $clog2(TILE);
  localparam int CW = $clog2(2 * TILE) + 1;
  localparam int OW = $clog2(MAX_OUT) + 1;
  wt_state_t state, next;
  logic [7:0] od1, od2;
  logic [3:0] id;
  logic skip, fire, rv, hit;
  logic [CW-1:0] issued, rcvd, n_reads;
  logic [OW-1:0] outst;
  logic [TILE*DATA_W-1:0] f1, f2;
  logic [ADDR_W-1:0] gen_addr;
  wt_addr_gen #(.ADDR_W(ADDR_W), .KW(KW)) u_addr (
    .base(wt_base_i),
    .od(issued >= CW'(TILE) ? od2 : od1),
    .id(id),
    .total_id(total_id_i),
    .k(issued[KW-1:0]),
    .addr(gen_addr)
  );
`ifdef WT_REUSE_EN
  logic tiles_ok;
  assign hit = tiles_ok && weight_od1_i == od1 && weight_od2_i == od2 && weight_id_i == id;
  // Tiles count as reusable only once a fetch has fully completed.
  always_ff @(posedge clk)
    if (reset) tiles_ok <= 1'b0;
    else if (state == FETCH) tiles_ok <= next == READY;
`else
  assign hit = 1'b0;
`endif
  always_comb begin
    n_reads = skip ? CW'(TILE) : CW'(2 * TILE);
    mem_req_o = state == FETCH && issued < n_reads && outst < OW'(MAX_OUT);
    fire = mem_req_o && mem_gnt_i;
    rv = state == FETCH && mem_rvalid_i && rcvd < n_reads;
    mem_addr_o = state == FETCH ? gen_addr : '0;
    weight_ready_o = state == READY || state == ACTIVE;
    wt_valid_o = state == ACTIVE;
    next = state == IDLE  ? (weight_prepare_i ? (hit ? READY : FETCH) : IDLE) :
           state == FETCH ? (rcvd == n_reads ? READY : FETCH) :
           state == READY ? (weight_start_i ? ACTIVE : READY) :
                            (weight_start_i ? ACTIVE : IDLE);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      od1 <= '0;
      od2 <= '0;
      id <= '0;
      skip <= 1'b0;
      issued <= '0;
      rcvd <= '0;
      outst <= '0;
      f1 <= '0;
      f2 <= '0;
    end else begin
      state <= next;
      if (state == IDLE && weight_prepare_i && !hit) begin
        od1 <= weight_od1_i;
        od2 <= weight_od2_i;
        id <= weight_id_i;
        skip <= weight_od2_i >= total_od_i;
        issued <= '0;
        rcvd <= '0;
        f1 <= '0;
        f2 <= '0;
      end
      if (fire) issued <= issued + 1'b1;
      if (rv) begin
        rcvd <= rcvd + 1'b1;
        if (rcvd < CW'(TILE)) f1[rcvd[KW-1:0]*DATA_W +: DATA_W] <= mem_rdata_i;
        else f2[rcvd[KW-1:0]*DATA_W +: DATA_W] <= mem_rdata_i;
      end
      outst <= outst + OW'(fire) - OW'(rv);
    end
  end
  assign wt_f1_o = f1;
  assign wt_f2_o = f2;
endmodule

// File: tb/tb_weight_fetch_controller.sv
// tb_weight_fetch_controller: scoreboard bench with an in-order, variable-latency weight memory model
module tb_weight_fetch_controller;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] od1 = '0, od2 = '0, tot_od = 8'd4;
  logic [3:0] id = '0, tot_id = 4'd3;
  logic prepare = 1'b0, start = 1'b0;
  logic [15:0] base = 16'h1000;
  logic ready, req, gnt = 1'b0, rvalid = 1'b0, valid;
  logic [15:0] addr;
  logic [7:0] rdata = '0;
  logic [127:0] f1, f2, exp_f1, exp_f2;
  typedef struct {logic [15:0] a; int due;} rsp_t;
  rsp_t pend[$];
  logic [15:0] exp_addr[$];
  int checks = 0, failures = 0, cyc = 0, grants = 0;
  int gnt_pct = 100, dly_min = 1, dly_max = 1;
  logic stall_prev = 1'b0;
  logic [15:0] prev_addr = '0;

  weight_fetch_controller dut (
    .clk(clk), .reset(reset),
    .weight_od1_i(od1), .weight_od2_i(od2), .weight_id_i(id),
    .weight_prepare_i(prepare), .weight_start_i(start),
    .total_id_i(tot_id), .total_od_i(tot_od), .wt_base_i(base),
    .weight_ready_o(ready), .mem_req_o(req), .mem_addr_o(addr),
    .mem_gnt_i(gnt), .mem_rvalid_i(rvalid), .mem_rdata_i(rdata),
    .wt_valid_o(valid), .wt_f1_o(f1), .wt_f2_o(f2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Memory model: decides gnt and drives responses half a cycle ahead of the sampling edge.
  always @(negedge clk) begin
    cyc++;
    check("outstanding_le_max", 128'(pend.size() > 4), 128'(0));
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      rvalid = 1'b1;
      rdata = pend[0].a[7:0];
      void'(pend.pop_front());
    end else begin
      rvalid = 1'b0;
      rdata = 8'($urandom);
    end
    if (stall_prev && req) check("addr_stable", 128'(addr), 128'(prev_addr));
    gnt = $urandom_range(99) < gnt_pct;
    stall_prev = req && !gnt;
    prev_addr = addr;
    if (req && gnt && !reset) begin
      grants++;
      if (exp_addr.size() == 0) check("unexpected_req", 128'(addr), 128'(0));
      else check("req_addr", 128'(addr), 128'(exp_addr.pop_front()));
      pend.push_back('{a: addr, due: cyc + $urandom_range(dly_max, dly_min)});
    end
  end

  task automatic push_exp(input logic [7:0] o1, input logic [7:0] o2, input logic [3:0] i);
    logic [15:0] a;
    exp_f1 = '0;
    exp_f2 = '0;
    for (int k = 0; k < 16; k++) begin
      a = base + 16'(((int'(o1) * int'(tot_id) + int'(i)) << 4) + k);
      exp_addr.push_back(a);
      exp_f1[k*8 +: 8] = a[7:0];
    end
    if (o2 < tot_od)
      for (int k = 0; k < 16; k++) begin
        a = base + 16'(((int'(o2) * int'(tot_id) + int'(i)) << 4) + k);
        exp_addr.push_back(a);
        exp_f2[k*8 +: 8] = a[7:0];
      end
  endtask

  task automatic fetch(input logic [7:0] o1, input logic [7:0] o2, input logic [3:0] i,
                       input int exp_lat, input bit hit, input bit with_start);
    int n, g0, lat;
    n = hit ? 0 : (o2 >= tot_od ? 16 : 32);
    if (!hit) push_exp(o1, o2, i);
    g0 = grants;
    od1 = o1;
    od2 = o2;
    id = i;
    prepare = 1'b1;
    start = with_start;
    @(posedge clk); #1;
    prepare = 1'b0;
    if (with_start) check("prepare_wins", 128'(req), 128'(1));
    lat = 0;
    while (!ready && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
    check("ready_seen", 128'(ready), 128'(1));
    if (exp_lat >= 0) check("ready_latency", 128'(lat), 128'(exp_lat));
    check("valid_at_ready", 128'(valid), 128'(0));
    check("req_count", 128'(grants - g0), 128'(n));
    check("exp_left", 128'(exp_addr.size()), 128'(0));
    check("tile_f1", f1, exp_f1);
    check("tile_f2", f2, exp_f2);
  endtask

  task automatic activate(input int n);
    start = 1'b1;
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      check("active_valid", 128'(valid), 128'(1));
      check("active_ready", 128'(ready), 128'(1));
      check("active_f1", f1, exp_f1);
      check("active_f2", f2, exp_f2);
    end
    start = 1'b0;
    @(posedge clk); #1;
    check("idle_ready", 128'(ready), 128'(0));
    check("idle_valid", 128'(valid), 128'(0));
  endtask

  initial begin
    int g0, t;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 128'(ready), 128'(0));
    check("rst_req", 128'(req), 128'(0));
    check("rst_valid", 128'(valid), 128'(0));
    check("rst_addr", 128'(addr), 128'(0));
    check("rst_f1", f1, 128'(0));
    check("rst_f2", f2, 128'(0));
    reset = 1'b0;
    @(posedge clk); #1;
    // Both filters, ideal memory.
    fetch(8'd0, 8'd1, 4'd2, 34, 1'b0, 1'b0);
    activate(10);
    // Filter 2 beyond total_od: half the reads, zero tile.
    tot_od = 8'd3;
    fetch(8'd2, 8'd3, 4'd2, 18, 1'b0, 1'b0);
    activate(3);
    // Prepare and start together: fetch happens first.
    tot_od = 8'd4;
    fetch(8'd1, 8'd2, 4'd1, 34, 1'b0, 1'b1);
    activate(2);
    // Random grants and response delays.
    gnt_pct = 50;
    dly_min = 1;
    dly_max = 5;
    fetch(8'd3, 8'd0, 4'd1, -1, 1'b0, 1'b0);
    activate(4);
    // Reset in the middle of a fetch with responses still in flight.
    gnt_pct = 100;
    dly_min = 3;
    dly_max = 5;
    push_exp(8'd1, 8'd3, 4'd0);
    od1 = 8'd1;
    od2 = 8'd3;
    id = 4'd0;
    prepare = 1'b1;
    @(posedge clk); #1;
    prepare = 1'b0;
    g0 = grants;
    t = 0;
    while (grants - g0 < 10 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check("reached_read10", 128'(grants - g0 >= 10), 128'(1));
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_req", 128'(req), 128'(0));
    check("abort_addr", 128'(addr), 128'(0));
    check("abort_ready", 128'(ready), 128'(0));
    reset = 1'b0;
    exp_addr.delete();
    repeat (10) @(posedge clk);
    #1;
    check("stale_drained", 128'(pend.size()), 128'(0));
    check("stale_f1", f1, 128'(0));
    check("stale_f2", f2, 128'(0));
    dly_min = 1;
    dly_max = 1;
    fetch(8'd1, 8'd3, 4'd0, 34, 1'b0, 1'b0);
    activate(2);
    // Same indices again.
`ifdef WT_REUSE_EN
    fetch(8'd1, 8'd3, 4'd0, 0, 1'b1, 1'b0);
`else
    fetch(8'd1, 8'd3, 4'd0, 34, 1'b0, 1'b0);
`endif
    activate(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
